// File: rtl/mash_accumulator.sv
// Three-stage cascaded accumulator core for a MASH 1-1-1 fractional-N modulator.
// Double-buffered fraction input, optional LFSR LSB dither, aligned registered carries.
module mash_accumulator #(
    parameter int unsigned WIDTH     = 16,
    parameter bit          DITHER_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync_clr,
    input  logic [WIDTH-1:0] frac_in,
    input  logic             frac_valid,
    output logic             frac_ready,
    input  logic             dither_on,
    output logic             c1,
    output logic             c2,
    output logic             c3
);

    localparam int unsigned LFSR_W    = 15;
    localparam logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(1);

    logic [WIDTH-1:0] acc1_q, acc1_d;
    logic [WIDTH-1:0] acc2_q, acc2_d;
    logic [WIDTH-1:0] acc3_q, acc3_d;
    logic             c1_q, c1_d;
    logic             c2_q, c2_d;
    logic             c3_q, c3_d;
    logic [WIDTH-1:0] f_act_q, f_act_d;
    logic [WIDTH-1:0] f_pend_q, f_pend_d;
    logic             pend_full_q, pend_full_d;
    logic             dither;
    logic [WIDTH:0]   sum1, sum2, sum3;

    // LSB dither source: x^15+x^14+1 Fibonacci LFSR, advancing on every enabled step
    if (DITHER_EN) begin : g_lfsr
        logic [LFSR_W-1:0] lfsr_q, lfsr_d;

        always_comb begin
            lfsr_d = lfsr_q;
            if (en) begin
                lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[14] ^ lfsr_q[13]};
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lfsr_q <= LFSR_SEED;
            end else begin
                lfsr_q <= lfsr_d;
            end
        end

        assign dither = dither_on & lfsr_q[0];
    end else begin : g_no_lfsr
        assign dither = 1'b0;
    end

    // Stage 2 and 3 see the freshly computed value of the stage before them
    always_comb begin
        sum1 = {1'b0, acc1_q} + {1'b0, f_act_q} + (WIDTH+1)'(dither);
        sum2 = {1'b0, acc2_q} + {1'b0, sum1[WIDTH-1:0]};
        sum3 = {1'b0, acc3_q} + {1'b0, sum2[WIDTH-1:0]};
    end

    always_comb begin
        acc1_d      = acc1_q;
        acc2_d      = acc2_q;
        acc3_d      = acc3_q;
        c1_d        = c1_q;
        c2_d        = c2_q;
        c3_d        = c3_q;
        f_act_d     = f_act_q;
        f_pend_d    = f_pend_q;
        pend_full_d = pend_full_q;

        if (sync_clr) begin
            acc1_d = '0;
            acc2_d = '0;
            acc3_d = '0;
            c1_d   = 1'b0;
            c2_d   = 1'b0;
            c3_d   = 1'b0;
        end else if (en) begin
            acc1_d = sum1[WIDTH-1:0];
            acc2_d = sum2[WIDTH-1:0];
            acc3_d = sum3[WIDTH-1:0];
            c1_d   = sum1[WIDTH];
            c2_d   = sum2[WIDTH];
            c3_d   = sum3[WIDTH];
        end

        // A full buffer refuses new words, so transfer and capture never coincide
        if (en && pend_full_q) begin
            f_act_d     = f_pend_q;
            pend_full_d = 1'b0;
        end else if (frac_valid && !pend_full_q) begin
            f_pend_d    = frac_in;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc1_q      <= '0;
            acc2_q      <= '0;
            acc3_q      <= '0;
            c1_q        <= 1'b0;
            c2_q        <= 1'b0;
            c3_q        <= 1'b0;
            f_act_q     <= '0;
            f_pend_q    <= '0;
            pend_full_q <= 1'b0;
        end else begin
            acc1_q      <= acc1_d;
            acc2_q      <= acc2_d;
            acc3_q      <= acc3_d;
            c1_q        <= c1_d;
            c2_q        <= c2_d;
            c3_q        <= c3_d;
            f_act_q     <= f_act_d;
            f_pend_q    <= f_pend_d;
            pend_full_q <= pend_full_d;
        end
    end

    assign frac_ready = !pend_full_q;
    assign c1         = c1_q;
    assign c2         = c2_q;
    assign c3         = c3_q;

endmodule

// File: tb/tb_mash_accumulator.sv
// Self-checking bench for mash_accumulator: hand-computed vector table, reference-model
// scoreboard, long-run carry counting, async reset and a narrow instance for dither.
module tb_mash_accumulator;

    localparam int unsigned W   = 16;
    localparam int unsigned MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0, sync_clr = 1'b0, frac_valid = 1'b0, dither_on = 1'b0;
    logic [W-1:0] frac_in = '0;
    logic         frac_ready, c1, c2, c3;

    logic         en4 = 1'b0, clr4 = 1'b0, val4 = 1'b0, dith4 = 1'b0;
    logic [3:0]   frac4 = '0;
    logic         rdy4, c1_4, c2_4, c3_4;

    always #5 clk = ~clk;

    mash_accumulator #(.WIDTH(W), .DITHER_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr),
        .frac_in(frac_in), .frac_valid(frac_valid), .frac_ready(frac_ready),
        .dither_on(dither_on), .c1(c1), .c2(c2), .c3(c3)
    );

    mash_accumulator #(.WIDTH(4), .DITHER_EN(1'b1)) u_w4 (
        .clk(clk), .rst(rst), .en(en4), .sync_clr(clr4),
        .frac_in(frac4), .frac_valid(val4), .frac_ready(rdy4),
        .dither_on(dith4), .c1(c1_4), .c2(c2_4), .c3(c3_4)
    );

    int total = 0;
    int bad   = 0;
    logic [3:0] sb_q[$];

    // reference model state
    int unsigned  m_acc1, m_acc2, m_acc3;
    logic         m_c1, m_c2, m_c3;
    int unsigned  m_fact, m_fpend;
    logic         m_pfull;
    logic [14:0]  m_lfsr;

    typedef struct {
        logic         en;
        logic         clr;
        logic         val;
        logic [W-1:0] f;
        logic [3:0]   exp_o;   // {frac_ready, c1, c2, c3} after the edge
    } vec_t;

    vec_t tab[15];

    task automatic model_reset();
        m_acc1 = 0; m_acc2 = 0; m_acc3 = 0;
        m_c1 = 1'b0; m_c2 = 1'b0; m_c3 = 1'b0;
        m_fact = 0; m_fpend = 0; m_pfull = 1'b0;
        m_lfsr = 15'h0001;
    endtask

    task automatic model_step(input logic e, input logic clr, input logic v,
                              input logic [W-1:0] f, input logic dith);
        int unsigned t1, t2, t3, d;
        logic rdy;
        d   = (dith && m_lfsr[0]) ? 1 : 0;
        rdy = !m_pfull;
        t1  = m_acc1 + m_fact + d;
        t2  = m_acc2 + (t1 % MOD);
        t3  = m_acc3 + (t2 % MOD);
        if (clr) begin
            m_acc1 = 0; m_acc2 = 0; m_acc3 = 0;
            m_c1 = 1'b0; m_c2 = 1'b0; m_c3 = 1'b0;
        end else if (e) begin
            m_acc1 = t1 % MOD; m_c1 = (t1 >= MOD);
            m_acc2 = t2 % MOD; m_c2 = (t2 >= MOD);
            m_acc3 = t3 % MOD; m_c3 = (t3 >= MOD);
        end
        if (e) begin
            m_lfsr = {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
            if (m_pfull) begin
                m_fact  = m_fpend;
                m_pfull = 1'b0;
            end
        end
        if (v && rdy) begin
            m_fpend = int'(f);
            m_pfull = 1'b1;
        end
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", nm, got, want, $time);
        end
    endtask

    // Drive one cycle; expected {ready,c1,c2,c3} is queued at drive time, compared after the edge
    task automatic cyc(input string nm, input logic e, input logic clr, input logic v,
                       input logic [W-1:0] f, input logic dith,
                       input bit use_tab, input logic [3:0] tab_exp);
        logic [3:0] want;
        en = e; sync_clr = clr; frac_valid = v; frac_in = f; dither_on = dith;
        model_step(e, clr, v, f, dith);
        sb_q.push_back(use_tab ? tab_exp : {!m_pfull, m_c1, m_c2, m_c3});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({nm, "_sb_empty"}, 32'(0), 32'(1));
        end else begin
            want = sb_q.pop_front();
            check(nm, 32'({frac_ready, c1, c2, c3}), 32'(want));
        end
    endtask

    initial begin
        int pulses;
        int cnt4;

        // dither off throughout the table
        tab[0]  = '{1'b0, 1'b0, 1'b1, 16'h1000, 4'b0000};
        tab[1]  = '{1'b0, 1'b0, 1'b1, 16'h2000, 4'b0000};
        tab[2]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'b1000};
        tab[3]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'b1000};
        tab[4]  = '{1'b0, 1'b0, 1'b1, 16'h8000, 4'b0000};
        tab[5]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'b1000};
        tab[6]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 4'b1000};
        tab[7]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'b1000};
        tab[8]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'b1101};
        tab[9]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'b1010};
        tab[10] = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'b1100};
        tab[11] = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'b1000};
        tab[12] = '{1'b0, 1'b0, 1'b0, 16'h0000, 4'b1000};
        tab[13] = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'b1101};
        tab[14] = '{1'b0, 1'b0, 1'b1, 16'h1234, 4'b0101};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'({frac_ready, c1, c2, c3}), 32'(4'b1000));
        check("reset_f_act", 32'(dut.f_act_q), 32'(0));
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            cyc($sformatf("table_row%0d", i), tab[i].en, tab[i].clr, tab[i].val,
                tab[i].f, 1'b0, 1'b1, tab[i].exp_o);
            if (i == 3) check("f_act_first_word", 32'(dut.f_act_q), 32'h1000);
            if (i == 6) check("f_act_kept_by_clr", 32'(dut.f_act_q), 32'h8000);
        end

        // asynchronous reset between edges with carries high and a word pending
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_outputs", 32'({frac_ready, c1, c2, c3}), 32'(4'b1000));
        en = 1'b0; sync_clr = 1'b0; frac_valid = 1'b0; dither_on = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // dithered run after reset: carry pattern depends on the LFSR restarting at 0x0001
        cyc("load_7fff", 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 60; i++)
            cyc("lfsr_restart", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b0000);

        // 0x4000 for a full 2^16 steps
        cyc("load_4000", 1'b0, 1'b0, 1'b1, 16'h4000, 1'b0, 1'b0, 4'b0000);
        cyc("apply_4000_clr", 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'b0000);
        pulses = 0;
        for (int i = 0; i < 65536; i++) begin
            cyc("run_4000", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'b0000);
            if (c1) pulses++;
        end
        check("c1_pulses_4000", 32'(pulses), 32'(16384));
        check("acc1_wrap_to_zero", 32'(dut.acc1_q), 32'(0));

        // zero fraction: silent without dither
        cyc("load_zero", 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 4'b0000);
        cyc("apply_zero_clr", 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'b0000);
        pulses = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc("zero_no_dither", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'b0000);
            if (c1 || c2 || c3) pulses++;
        end
        check("zero_frac_no_carries", 32'(pulses), 32'(0));

        // dither on: main instance against the model, 4-bit instance must pulse c1
        en4 = 1'b1; dith4 = 1'b1;
        cnt4 = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc("zero_dither", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b0000);
            if (c1_4) cnt4++;
        end
        check("dither_c1_pulses_w4", 32'(cnt4 > 0), 32'(1));
        en4 = 1'b0; dith4 = 1'b0;

        // random traffic against the model
        for (int i = 0; i < 300; i++)
            cyc("random", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
                1'b0, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
